// File: rtl/set_cmd_dispatch.sv
// Command front-end for the circle point-count engine: queues host commands,
// issues them one at a time over the engine's en/busy/valid handshake and
// returns each result paired with the command's tag.
// Latency: push-to-set_en is 2 edges (issue decision registered); set_valid to res_valid is 1 edge.
// Backpressure: cmd_ready = !full; a held result (res_valid && !res_ready) blocks further issue.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_central/cmd_radius/cmd_tag command payload
//   set_en/set_central/set_radius  engine start pulse and operands
//   set_busy/set_valid             engine status and one-cycle result strobe
//   set_candidate                  engine result
//   res_valid/res_ready            host result handshake
//   res_count/res_tag              captured result and its tag
//   pending                        queued commands plus the one in flight
module set_cmd_dispatch #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_central,
    input  logic [3:0]               cmd_radius,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     set_en,
    output logic [7:0]               set_central,
    output logic [3:0]               set_radius,
    input  logic                     set_busy,
    input  logic                     set_valid,
    input  logic [7:0]               set_candidate,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_count,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 8 + 4 + TAG_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_VALID,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic             capture;
    logic [EW-1:0]    head;
    logic [TAG_W-1:0] fly_tag;

    // Full is derived from the registered count only, so a pop in the same
    // cycle cannot raise cmd_ready until the following cycle.
    assign cmd_ready = (count != (AW+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign pending   = count + (AW+1)'(state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // Never start while a result is parked or the engine has not
                // yet dropped busy from the previous command.
                if (count != '0 && !res_valid && !set_busy) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (set_busy) begin
                    state_nxt = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (set_valid) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!set_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_central, cmd_radius, cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- engine issue ----------------
    // Operands load only on issue, so they stay put through WAIT_BUSY and
    // keep their last values while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_en      <= 1'b0;
            set_central <= '0;
            set_radius  <= '0;
            fly_tag     <= '0;
        end else begin
            set_en <= pop;
            if (pop) begin
                {set_central, set_radius, fly_tag} <= head;
            end
        end
    end

    // ---------------- result slot ----------------
    // Capture and drain never coincide: issue requires an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_count <= '0;
            res_tag   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_count <= set_candidate;
            res_tag   <= fly_tag;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
